// File: rtl/i2c_read_rdata.sv
// i2c_read_rdata: bit-banged I2C master that reads 1..MAX_BYTES data bytes from a slave register.
// Bus sequence: START, addr+W, pointer, repeated START, addr+R, N data bytes (ACK all but the
// last, which gets NACK), STOP. One PT_CK cycle is one quarter of an SCL bit.
//
// Ports:
//   PT_CK         quarter-bit clock
//   RESET_N       asynchronous active-low reset
//   GO            level request; must be seen high then low in IDLE/ARM to start
//   SLAVE_ADDRESS [7:1] 7-bit slave address, [0] ignored
//   REG_ADDR      register pointer written before the read
//   BYTE_NUM      bytes to read, 0 treated as 1, clamped to MAX_BYTES
//   SDAI          sampled SDA line
//   SDAO/SCLO     open-drain drives, 1 = release, 0 = pull low
//   END_OK        1 = idle or done, 0 = busy
//   ACK_ERR       slave NACKed an address or pointer byte in the last transaction
//   RDATA         received bytes, last byte in [7:0]
//   BYTE          data bytes received so far
//   ST            current state
module i2c_read_rdata #(
  parameter int unsigned MAX_BYTES = 4
) (
  input  logic                   PT_CK,
  input  logic                   RESET_N,
  input  logic                   GO,
  input  logic [7:0]             SLAVE_ADDRESS,
  input  logic [7:0]             REG_ADDR,
  input  logic [2:0]             BYTE_NUM,
  input  logic                   SDAI,
  output logic                   SDAO,
  output logic                   SCLO,
  output logic                   END_OK,
  output logic                   ACK_ERR,
  output logic [8*MAX_BYTES-1:0] RDATA,
  output logic [2:0]             BYTE,
  output logic [4:0]             ST
);

  localparam int unsigned W = 8 * MAX_BYTES;
  localparam logic [2:0] MaxNum = 3'(MAX_BYTES);

  typedef enum logic [4:0] {
    StIdle   = 5'd0,
    StArm    = 5'd1,
    StStart  = 5'd2,
    StWaddr  = 5'd3,
    StPtr    = 5'd4,
    StRstart = 5'd5,
    StRaddr  = 5'd6,
    StData   = 5'd7,
    StStop   = 5'd8,
    StDone   = 5'd9
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     step_q, step_d;   // quarter within a bit, or step within START/RSTART/STOP
  logic [3:0]     bit_q, bit_d;     // 0..7 data bits, 8 = acknowledge slot
  logic [6:0]     addr_q;
  logic [7:0]     reg_q;
  logic [2:0]     num_q;
  logic [2:0]     byte_q;
  logic [W-1:0]   rdata_q;
  logic           ack_err_q;
  logic           sdao_q, sdao_d;
  logic           sclo_q, sclo_d;
  logic           end_ok_q, end_ok_d;

  logic           unused_addr_lsb;
  logic           start_txn;
  logic           last_quarter;
  logic           ack_slot;
  logic           more_bytes;
  logic           ctrl_byte;
  logic [2:0]     num_clamped;
  logic [7:0]     tx_byte;
  logic           bit_val;

  assign unused_addr_lsb = SLAVE_ADDRESS[0];

  assign start_txn    = (state_q == StArm) && !GO;
  assign last_quarter = (step_q == 2'd3);
  assign ack_slot     = (bit_q == 4'd8);
  assign more_bytes   = ({1'b0, byte_q} + 4'd1) < {1'b0, num_q};
  assign ctrl_byte    = (state_q == StWaddr) || (state_q == StPtr) || (state_q == StRaddr);

  assign num_clamped = (BYTE_NUM == 3'd0)  ? 3'd1   :
                       (BYTE_NUM > MaxNum) ? MaxNum : BYTE_NUM;

  // State register and datapath registers
  always_ff @(posedge PT_CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      step_q    <= 2'd0;
      bit_q     <= 4'd0;
      addr_q    <= 7'd0;
      reg_q     <= 8'd0;
      num_q     <= 3'd1;
      byte_q    <= 3'd0;
      rdata_q   <= '0;
      ack_err_q <= 1'b0;
      sdao_q    <= 1'b1;
      sclo_q    <= 1'b1;
      end_ok_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      bit_q    <= bit_d;
      sdao_q   <= sdao_d;
      sclo_q   <= sclo_d;
      end_ok_q <= end_ok_d;
      if (start_txn) begin
        addr_q    <= SLAVE_ADDRESS[7:1];
        reg_q     <= REG_ADDR;
        num_q     <= num_clamped;
        byte_q    <= 3'd0;
        rdata_q   <= '0;
        ack_err_q <= 1'b0;
      end
      if (ctrl_byte && last_quarter && ack_slot && SDAI) begin
        ack_err_q <= 1'b1;
      end
      if ((state_q == StData) && last_quarter) begin
        if (!ack_slot) begin
          rdata_q <= {rdata_q[W-2:0], SDAI};
        end else begin
          byte_q <= byte_q + 3'd1;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    bit_d   = bit_q;
    unique case (state_q)
      StIdle: begin
        if (GO) state_d = StArm;
      end
      StArm: begin
        if (!GO) begin
          state_d = StStart;
          step_d  = 2'd0;
          bit_d   = 4'd0;
        end
      end
      StStart: begin
        if (step_q == 2'd1) begin
          state_d = StWaddr;
          step_d  = 2'd0;
          bit_d   = 4'd0;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      StWaddr, StPtr, StRaddr, StData: begin
        if (!last_quarter) begin
          step_d = step_q + 2'd1;
        end else if (!ack_slot) begin
          step_d = 2'd0;
          bit_d  = bit_q + 4'd1;
        end else begin
          step_d = 2'd0;
          bit_d  = 4'd0;
          if (ctrl_byte && SDAI) begin
            state_d = StStop;
          end else begin
            unique case (state_q)
              StWaddr: state_d = StPtr;
              StPtr:   state_d = StRstart;
              StRaddr: state_d = StData;
              default: state_d = more_bytes ? StData : StStop;
            endcase
          end
        end
      end
      StRstart: begin
        if (step_q == 2'd3) begin
          state_d = StRaddr;
          step_d  = 2'd0;
          bit_d   = 4'd0;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      StStop: begin
        if (step_q == 2'd2) begin
          state_d = StDone;
          step_d  = 2'd0;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: computed from the next state so every output is a register
  always_comb begin
    unique case (state_d)
      StWaddr: tx_byte = {addr_q, 1'b0};
      StPtr:   tx_byte = reg_q;
      StRaddr: tx_byte = {addr_q, 1'b1};
      default: tx_byte = 8'hFF;
    endcase

    if (bit_d == 4'd8) begin
      // Master ACK on data bytes uses the count before the end-of-byte increment
      bit_val = (state_d == StData) ? !more_bytes : 1'b1;
    end else begin
      bit_val = tx_byte[3'd7 - bit_d[2:0]];
    end

    sdao_d   = 1'b1;
    sclo_d   = 1'b1;
    end_ok_d = 1'b0;
    unique case (state_d)
      StIdle, StArm, StDone: begin
        end_ok_d = 1'b1;
      end
      StStart: begin
        sdao_d = 1'b0;
        sclo_d = (step_d == 2'd0);
      end
      StRstart: begin
        sdao_d = (step_d < 2'd2);
        sclo_d = ^step_d;
      end
      StStop: begin
        sdao_d = (step_d == 2'd2);
        sclo_d = (step_d != 2'd0);
      end
      default: begin
        // Q0 lowers SCL with SDA held; SDA only moves in Q1
        sclo_d = step_d[1];
        sdao_d = (step_d == 2'd0) ? sdao_q : bit_val;
      end
    endcase
  end

  assign SDAO    = sdao_q;
  assign SCLO    = sclo_q;
  assign END_OK  = end_ok_q;
  assign ACK_ERR = ack_err_q;
  assign RDATA   = rdata_q;
  assign BYTE    = byte_q;
  assign ST      = state_q;

endmodule

// File: tb/tb_i2c_read_rdata.sv
module tb_i2c_read_rdata;

  logic        PT_CK = 1'b0;
  logic        RESET_N;
  logic        GO;
  logic [7:0]  SLAVE_ADDRESS;
  logic [7:0]  REG_ADDR;
  logic [2:0]  BYTE_NUM;
  logic        SDAI;
  logic        SDAO;
  logic        SCLO;
  logic        END_OK;
  logic        ACK_ERR;
  logic [31:0] RDATA;
  logic [2:0]  BYTE;
  logic [4:0]  ST;

  i2c_read_rdata #(.MAX_BYTES(4)) dut (
    .PT_CK         (PT_CK),
    .RESET_N       (RESET_N),
    .GO            (GO),
    .SLAVE_ADDRESS (SLAVE_ADDRESS),
    .REG_ADDR      (REG_ADDR),
    .BYTE_NUM      (BYTE_NUM),
    .SDAI          (SDAI),
    .SDAO          (SDAO),
    .SCLO          (SCLO),
    .END_OK        (END_OK),
    .ACK_ERR       (ACK_ERR),
    .RDATA         (RDATA),
    .BYTE          (BYTE),
    .ST            (ST)
  );

  always #5 PT_CK = ~PT_CK;

  // Slave model: open-drain wired-AND with the master
  logic       slave_sda = 1'b1;
  logic       nack_waddr = 1'b0;
  logic [7:0] resp [4];
  logic [7:0] log_q [$];
  logic [7:0] acks;
  int         n_acks;
  int         n_starts;
  int         n_stops;
  int         clr_req = 0;

  assign SDAI = SDAO & slave_sda;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // phase: 0 address byte, 1 written byte, 2 read data byte, 3 finished
  initial begin : slave
    int         clr_seen;
    int         bitn;
    int         phase;
    int         next_phase;
    int         didx;
    logic [7:0] rx;
    logic [7:0] cur;
    logic       prev_scl;
    logic       prev_sda;
    logic       sda;
    logic       last_ack;
    clr_seen = 0; bitn = 0; phase = 0; next_phase = 1; didx = 0;
    rx = 8'h0; cur = 8'h0; prev_scl = 1'b1; prev_sda = 1'b1; last_ack = 1'b0;
    forever begin
      @(negedge PT_CK);
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        bitn = 0; phase = 0; didx = 0; slave_sda = 1'b1;
        log_q.delete(); acks = 8'h0; n_acks = 0; n_starts = 0; n_stops = 0;
      end
      sda = SDAO & slave_sda;
      if (SCLO && prev_scl && prev_sda && !sda) begin
        n_starts++; bitn = 0; phase = 0; slave_sda = 1'b1;
      end else if (SCLO && prev_scl && !prev_sda && sda) begin
        n_stops++;
      end else if (SCLO && !prev_scl) begin
        if (bitn < 8) rx = {rx[6:0], sda};
        else if (bitn == 8 && phase == 2) begin
          acks = {acks[6:0], sda}; n_acks++; last_ack = sda;
        end
        bitn++;
      end else if (!SCLO && prev_scl) begin
        if (bitn == 8) begin
          log_q.push_back(rx);
          if (phase == 0) begin
            next_phase = rx[0] ? 2 : 1;
            slave_sda = nack_waddr && !rx[0];
          end else if (phase == 1) slave_sda = 1'b0;
          else slave_sda = 1'b1;
        end else if (bitn == 9) begin
          bitn = 0;
          if (phase == 0) phase = next_phase;
          else if (phase == 2 && last_ack) phase = 3;
          if (phase == 2) begin
            cur = resp[didx % 4]; didx++; slave_sda = cur[7];
          end else slave_sda = 1'b1;
        end else if (phase == 2 && bitn >= 1 && bitn <= 7) begin
          slave_sda = cur[7 - bitn];
        end
      end
      prev_scl = SCLO;
      prev_sda = SDAO & slave_sda;
    end
  end

  function automatic logic [31:0] pack_log();
    logic [31:0] v = 32'h0;
    for (int i = 0; i < log_q.size() && i < 4; i++) v = {v[23:0], log_q[i]};
    return v;
  endfunction

  // Raise GO for 'hold' cycles, counting any bus or state activity while held
  task automatic start_txn(input logic [7:0] a, input logic [7:0] r, input logic [2:0] n,
                           input int hold, output int act);
    act = 0;
    @(posedge PT_CK); #1;
    clr_req++;
    SLAVE_ADDRESS = a; REG_ADDR = r; BYTE_NUM = n; GO = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge PT_CK);
      if (!SCLO || !SDAO || !END_OK || (i > 0 && ST != 5'd1)) act++;
      @(posedge PT_CK);
    end
    #1 GO = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, output int busy, output logic err_at_start);
    bit done = 1'b0;
    busy = 0;
    err_at_start = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge PT_CK);
      if (!END_OK) begin
        if (busy == 0) err_at_start = ACK_ERR;
        busy++;
        if (toggle) GO = (busy < 100) ? ((busy % 10) < 5) : 1'b0;
      end else if (busy > 0) begin
        done = 1'b1;
      end
    end
    GO = 1'b0;
    check("done_in_budget", 32'(done), 32'd1);
  endtask

  int   act;
  int   busy;
  logic err0;
  bit   found;

  initial begin
    RESET_N = 1'b0; GO = 1'b0; SLAVE_ADDRESS = 8'h0; REG_ADDR = 8'h0; BYTE_NUM = 3'd0;
    resp[0] = 8'h0; resp[1] = 8'h0; resp[2] = 8'h0; resp[3] = 8'h0;
    repeat (3) @(posedge PT_CK);
    @(negedge PT_CK);
    check("rst_st", 32'(ST), 32'd0);
    check("rst_lines", {30'd0, SDAO, SCLO}, 32'd3);
    check("rst_end_ok", 32'(END_OK), 32'd1);
    check("rst_ack_err", 32'(ACK_ERR), 32'd0);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_byte", 32'(BYTE), 32'd0);
    RESET_N = 1'b1;

    // Single byte, GO held high for 50 cycles first
    resp[0] = 8'hA5;
    start_txn(8'h90, 8'h12, 3'd1, 50, act);
    check("hold_no_activity", 32'(act), 32'd0);
    wait_done(1'b0, busy, err0);
    check("t1_busy", 32'(busy), 32'd153);
    check("t1_rdata", RDATA, 32'h000000A5);
    check("t1_ack_err", 32'(ACK_ERR), 32'd0);
    check("t1_byte", 32'(BYTE), 32'd1);
    check("t1_nbytes", 32'(log_q.size()), 32'd4);
    check("t1_bus", pack_log(), 32'h901291A5);
    check("t1_nack_last", {24'd0, acks}, 32'h1);
    check("t1_starts", 32'(n_starts), 32'd2);
    check("t1_stops", 32'(n_stops), 32'd1);

    // Four bytes with GO toggling during the transfer
    resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33; resp[3] = 8'h44;
    start_txn(8'h90, 8'h12, 3'd4, 1, act);
    wait_done(1'b1, busy, err0);
    check("t2_busy", 32'(busy), 32'd261);
    check("t2_rdata", RDATA, 32'h11223344);
    check("t2_byte", 32'(BYTE), 32'd4);
    check("t2_n_acks", 32'(n_acks), 32'd4);
    check("t2_acks", {28'd0, acks[3:0]}, 32'h1);
    check("t2_nbytes", 32'(log_q.size()), 32'd7);
    check("t2_ack_err", 32'(ACK_ERR), 32'd0);

    // Slave NACKs the write address
    nack_waddr = 1'b1;
    start_txn(8'h90, 8'h12, 3'd2, 1, act);
    wait_done(1'b0, busy, err0);
    check("t3_busy", 32'(busy), 32'd41);
    check("t3_ack_err", 32'(ACK_ERR), 32'd1);
    check("t3_rdata", RDATA, 32'h0);
    check("t3_byte", 32'(BYTE), 32'd0);
    check("t3_nbytes", 32'(log_q.size()), 32'd1);
    check("t3_stops", 32'(n_stops), 32'd1);
    nack_waddr = 1'b0;

    // BYTE_NUM=0 reads one byte; ACK_ERR clears at the start
    resp[0] = 8'h3C;
    start_txn(8'h90, 8'h12, 3'd0, 1, act);
    wait_done(1'b0, busy, err0);
    check("t4_err_cleared", 32'(err0), 32'd0);
    check("t4_ack_err", 32'(ACK_ERR), 32'd0);
    check("t4_busy", 32'(busy), 32'd153);
    check("t4_rdata", RDATA, 32'h0000003C);
    check("t4_byte", 32'(BYTE), 32'd1);
    check("t4_acks", {24'd0, acks}, 32'h1);

    // Two bytes, address LSB ignored
    resp[0] = 8'h5A; resp[1] = 8'hC3;
    start_txn(8'hA1, 8'h07, 3'd2, 1, act);
    wait_done(1'b0, busy, err0);
    check("t5_busy", 32'(busy), 32'd189);
    check("t5_rdata", RDATA, 32'h00005AC3);
    check("t5_bus", pack_log(), 32'hA007A15A);
    check("t5_acks", {30'd0, acks[1:0]}, 32'h1);

    // Reset in bit 4 of the first data byte
    resp[0] = 8'hFF; resp[1] = 8'hFF; resp[2] = 8'hFF; resp[3] = 8'hFF;
    start_txn(8'h90, 8'h12, 3'd4, 1, act);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge PT_CK);
      if (ST == 5'd7) found = 1'b1;
    end
    check("t6_reached_data", 32'(found), 32'd1);
    repeat (14) @(negedge PT_CK);
    check("t6_rdata_partial", RDATA, 32'h7);
    RESET_N = 1'b0;
    #1;
    check("t6_lines", {30'd0, SDAO, SCLO}, 32'd3);
    check("t6_end_ok", 32'(END_OK), 32'd1);
    check("t6_rdata", RDATA, 32'h0);
    check("t6_st", 32'(ST), 32'd0);
    @(negedge PT_CK);
    RESET_N = 1'b1;

    resp[0] = 8'h7E;
    start_txn(8'h90, 8'h12, 3'd1, 1, act);
    wait_done(1'b0, busy, err0);
    check("t7_busy", 32'(busy), 32'd153);
    check("t7_rdata", RDATA, 32'h0000007E);
    check("t7_ack_err", 32'(ACK_ERR), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_read_rdata.md
Name: i2c_read_rdata

Overview:
- Bit-banged I2C master that reads 1–4 data bytes from a register of a slave device.
- Sequence: START, slave address + W, register pointer, repeated START, slave address + R, N data bytes (master ACK on each byte except the last, which gets NACK), STOP.
- It is the read-direction counterpart of the existing I2C write engine. It is driven from the same PT_CK tick and shares the open-drain SDA/SCL pad logic and the GO/END_OK handshake.

Parameters:
- MAX_BYTES, 4, maximum data bytes per transaction; sets the RDATA width (8*MAX_BYTES).

Ports:
- PT_CK  in  1  clock; one PT_CK cycle = one quarter of an SCL bit period.
- RESET_N  in  1  asynchronous active-low reset.
- GO  in  1  transaction request (level handshake, see Behaviour).
- SLAVE_ADDRESS  in  8  bits [7:1] are the 7-bit slave address; bit 0 is ignored.
- REG_ADDR  in  8  register pointer written before the read.
- BYTE_NUM  in  3  data bytes to read, 1..MAX_BYTES; 0 is treated as 1.
- SDAI  in  1  sampled SDA line.
- SDAO  out  1  SDA drive; 1 = release (pulled high), 0 = pull low.
- SCLO  out  1  SCL drive, same open-drain sense as SDAO.
- END_OK  out  1  1 = idle or done, 0 = busy.
- ACK_ERR  out  1  1 = slave NACKed an address or pointer byte in the last transaction.
- RDATA  out  8*MAX_BYTES  received data; the first byte lands in the most significant used byte, the last byte in [7:0].
- BYTE  out  3  number of data bytes received so far (test visibility).
- ST  out  5  current state (test visibility).

Behaviour:
- Reset (async, RESET_N=0):
  - ST=IDLE, SDAO=1, SCLO=1, END_OK=1, ACK_ERR=0, RDATA=0, BYTE=0, bit counter=0.
  - Reset mid-transaction aborts immediately with no STOP generated. Lines are released.
- IDLE: lines released, END_OK=1. GO=1 -> ARM.
- ARM: waits for GO=0. The transaction starts on the cycle after GO is first seen low.
  - Next cycle: END_OK=0, ACK_ERR=0, RDATA=0, BYTE=0, latch SLAVE_ADDRESS, REG_ADDR and BYTE_NUM (clamped); -> START.
- START, 2 cycles:
  - {SDAO,SCLO}=01
  - then 00.
- Byte transfer: 9 bits, MSB first, 4 cycles per bit:
  - Q0: SCLO=0.
  - Q1: SDAO=bit value.
  - Q2: SCLO=1.
  - Q3: sample SDAI, hold SCLO=1.
  - Q0 of the next bit drives SCLO low.
- Phase order:
  - WADDR: {addr[7:1],0}, then ACK slot with SDAO=1.
  - PTR: REG_ADDR, then ACK slot.
  - RSTART.
  - RADDR: {addr[7:1],1}, then ACK slot.
  - DATA × N.
  - STOP.
- ACK slots after WADDR/PTR/RADDR: SDAI=1 in Q3 (NACK) sets ACK_ERR=1 and jumps to STOP. No further bytes are sent and RDATA stays at 0.
- DATA byte:
  - Bits 1–8: SDAO=1; SDAI sampled in Q3 is shifted into RDATA from the LSB (RDATA <= {RDATA, SDAI}).
  - Bit 9 (master ACK): SDAO=0 if BYTE+1 < N, else SDAO=1 (NACK). BYTE increments at the end of bit 9.
- RSTART, 4 cycles, {SDAO,SCLO}: 10, 11, 01, 00.
- STOP, 3 cycles, {SDAO,SCLO}: 00, 01, 11.
- DONE, 1 cycle: END_OK=1, lines released, RDATA and ACK_ERR hold; -> IDLE.
- Busy cycles (END_OK low) for a clean transaction = 117 + 36·N.
- SDA changes only while SCLO=0, except during START/RSTART/STOP.
- GO changes while busy are ignored. A new transaction needs GO to rise again in IDLE.
- RDATA bytes above 8·N are 0.
- All outputs are registered.

Test Plan:
- Single-byte read: slave model ACKs all bytes and returns 0xA5; SLAVE_ADDRESS=0x90, REG_ADDR=0x12, BYTE_NUM=1, GO pulse -> bus shows 0x90, 0x12, RSTART, 0x91, then 0xA5 with master NACK, then STOP. Required: RDATA=0x000000A5, ACK_ERR=0, BYTE=1, END_OK low for exactly 153 cycles.
- Four-byte read: slave returns 0x11, 0x22, 0x33, 0x44 -> RDATA=0x11223344; master ACK (SDA=0) after the first three bytes and NACK after the fourth; END_OK low for 261 cycles.
- Address NACK: slave does not ACK WADDR -> ACK_ERR=1, STOP follows immediately after the first ACK slot, RDATA=0, END_OK low for 2+36+3=41 cycles.
- BYTE_NUM=0: behaves exactly like BYTE_NUM=1 (one byte read, NACKed).
- Handshake: GO held high for 50 cycles -> no bus activity until GO falls. GO toggled during a transfer -> no effect. A second GO after DONE starts a new read, and ACK_ERR clears at that start.
- Reset mid-transfer: assert RESET_N=0 during bit 4 of a DATA byte -> in the same cycle SDAO=1, SCLO=1, END_OK=1, RDATA=0, ST=IDLE. The next GO completes a normal read.
